// File: rtl/flash_pkg.sv
// Shared JS28F640 command-set constants, status-register bit map and
// sequencer/bus-cycle types for the flash read/write blocks.
package flash_pkg;

  localparam logic [7:0] FL_CMD_PROGRAM = 8'h40;
  localparam logic [7:0] FL_CMD_ERASE   = 8'h20;
  localparam logic [7:0] FL_CMD_CONFIRM = 8'hD0;
  localparam logic [7:0] FL_CMD_CLRSR   = 8'h50;
  localparam logic [7:0] FL_CMD_RDARR   = 8'hFF;

  localparam int SR_READY     = 7;
  localparam int SR_ERASE_ERR = 5;
  localparam int SR_PROG_ERR  = 4;
  localparam int SR_VPEN_ERR  = 3;
  localparam int SR_LOCK_ERR  = 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CMD1, S_CMD2, S_POLL, S_CLRSR, S_RDARR, S_DONE
  } seq_state_e;

  typedef enum logic [2:0] {
    BC_IDLE, BC_SETUP, BC_ACTIVE, BC_HOLD, BC_RECOVER
  } bc_phase_e;

  typedef struct packed {
    logic        wr;
    logic [22:0] addr;
    logic [15:0] data;
  } bc_req_t;

  function automatic logic sr_failed(input logic [7:0] sr);
    return sr[SR_ERASE_ERR] | sr[SR_PROG_ERR] | sr[SR_VPEN_ERR] | sr[SR_LOCK_ERR];
  endfunction

  function automatic logic [15:0] cmd_word(input logic [7:0] c);
    return {8'h00, c};
  endfunction

endpackage

// File: rtl/flash_bus_cycle.sv
// Single flash bus cycle engine: one write (SETUP/ACTIVE/HOLD/RECOVER) or
// read (SETUP/ACTIVE/RECOVER) per start; a new start is taken during RECOVER.
module flash_bus_cycle
  import flash_pkg::*;
#(
  parameter int WE_CYCLES = 3,
  parameter int RD_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  bc_req_t     req_i,
  output logic        done_o,
  output logic [7:0]  rdata_o,
  output logic [22:0] fl_addr_o,
  output logic [15:0] fl_data_o,
  output logic        fl_data_oe_o,
  input  logic [15:0] fl_data_i,
  output logic        fl_we_n_o,
  output logic        fl_oe_n_o,
  output logic        fl_ce_n_o
);

  localparam int MAXC = (WE_CYCLES > RD_CYCLES) ? WE_CYCLES : RD_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] WE_LAST = CW'(WE_CYCLES - 1);
  localparam logic [CW-1:0] RD_LAST = CW'(RD_CYCLES - 1);

  bc_phase_e   ph_q;
  logic        wr_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]  rdata_q;
  logic [22:0] addr_q;
  logic [15:0] data_q;
  logic        doe_q, we_n_q, oe_n_q, ce_n_q;

  // Only the status byte matters; the upper data lanes are don't-care here.
  logic unused_hi;
  assign unused_hi = ^fl_data_i[15:8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q    <= BC_IDLE;
      wr_q    <= 1'b0;
      cnt_q   <= '0;
      rdata_q <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      doe_q   <= 1'b0;
      we_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      ce_n_q  <= 1'b1;
    end else begin
      case (ph_q)
        BC_SETUP: begin
          ph_q   <= BC_ACTIVE;
          cnt_q  <= '0;
          we_n_q <= !wr_q;
          oe_n_q <= wr_q;
        end
        BC_ACTIVE: begin
          if (cnt_q == (wr_q ? WE_LAST : RD_LAST)) begin
            if (wr_q) begin
              ph_q   <= BC_HOLD;
              we_n_q <= 1'b1;
            end else begin
              ph_q    <= BC_RECOVER;
              oe_n_q  <= 1'b1;
              ce_n_q  <= 1'b1;
              rdata_q <= fl_data_i[7:0];
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        BC_HOLD: begin
          ph_q   <= BC_RECOVER;
          ce_n_q <= 1'b1;
          doe_q  <= 1'b0;
        end
        default: begin
          // IDLE and RECOVER: strobes are already released, so back-to-back
          // cycles chain without a dead clock.
          if (start_i) begin
            ph_q   <= BC_SETUP;
            wr_q   <= req_i.wr;
            addr_q <= req_i.addr;
            data_q <= req_i.data;
            doe_q  <= req_i.wr;
            ce_n_q <= 1'b0;
          end else begin
            ph_q <= BC_IDLE;
          end
        end
      endcase
    end
  end

  assign done_o       = (ph_q == BC_RECOVER);
  assign rdata_o      = rdata_q;
  assign fl_addr_o    = addr_q;
  assign fl_data_o    = data_q;
  assign fl_data_oe_o = doe_q;
  assign fl_we_n_o    = we_n_q;
  assign fl_oe_n_o    = oe_n_q;
  assign fl_ce_n_o    = ce_n_q;

endmodule

// File: rtl/flash_writer.sv
// JS28F640 program/erase sequencer: command writes, status polling, clear
// status and read-array restore. Define FLASH_WRITER_TIMEOUT_EN to bound polling.
module flash_writer
  import flash_pkg::*;
#(
  parameter int WE_CYCLES  = 3,
  parameter int RD_CYCLES  = 3,
  parameter int POLL_LIMIT = 2500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid_i,
  input  logic        cmd_op_i,
  input  logic [22:0] cmd_addr_i,
  input  logic [15:0] cmd_data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [7:0]  status_o,
  output logic [22:0] flAddr_o,
  output logic [15:0] flData_o,
  output logic        flDataOe_o,
  input  logic [15:0] flData_i,
  output logic        flWE_o,
  output logic        flOE_o,
  output logic        flCE_o,
  output logic        flRst_o,
  output logic        flByte_o,
  output logic        flVpen_o
);

  seq_state_e  state_q;
  logic        op_q;
  logic [22:0] addr_q;
  logic [15:0] data_q;
  logic        busy_q, done_q, error_q;
  logic [7:0]  status_q;

  bc_req_t     req;
  logic        bc_start, bc_done;
  logic [7:0]  bc_rdata;
  logic        sr_ready, poll_abort, poll_exit;

  assign sr_ready  = bc_rdata[SR_READY];
  assign poll_exit = sr_ready | poll_abort;

`ifdef FLASH_WRITER_TIMEOUT_EN
  localparam int PW = $clog2(POLL_LIMIT + 1);
  logic [PW-1:0] poll_cnt_q;

  // Counts completed status reads; the abort fires on the read that reaches the limit.
  assign poll_abort = (poll_cnt_q == PW'(POLL_LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 poll_cnt_q <= '0;
    else if (state_q != S_POLL) poll_cnt_q <= '0;
    else if (bc_done)           poll_cnt_q <= poll_cnt_q + 1'b1;
  end
`else
  localparam int unused_poll_limit = POLL_LIMIT;
  assign poll_abort = 1'b0;
`endif

  // Next bus cycle is launched in the same clock the current one reports done.
  always_comb begin
    bc_start = 1'b0;
    req.wr   = 1'b1;
    req.addr = addr_q;
    req.data = data_q;
    case (state_q)
      S_IDLE: begin
        bc_start = cmd_valid_i;
        req.addr = cmd_addr_i & ~23'h1;
        req.data = cmd_word(cmd_op_i ? FL_CMD_ERASE : FL_CMD_PROGRAM);
      end
      S_CMD1: begin
        bc_start = bc_done;
        req.data = op_q ? cmd_word(FL_CMD_CONFIRM) : data_q;
      end
      S_CMD2: begin
        bc_start = bc_done;
        req.wr   = 1'b0;
      end
      S_POLL: begin
        bc_start = bc_done;
        if (poll_exit) req.data = cmd_word(FL_CMD_CLRSR);
        else           req.wr   = 1'b0;
      end
      S_CLRSR: begin
        bc_start = bc_done;
        req.data = cmd_word(FL_CMD_RDARR);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= 1'b0;
      addr_q   <= '0;
      data_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      status_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (cmd_valid_i) begin
          op_q    <= cmd_op_i;
          addr_q  <= cmd_addr_i & ~23'h1;
          data_q  <= cmd_data_i;
          error_q <= 1'b0;
          busy_q  <= 1'b1;
          state_q <= S_CMD1;
        end
        S_CMD1:  if (bc_done) state_q <= S_CMD2;
        S_CMD2:  if (bc_done) state_q <= S_POLL;
        S_POLL: if (bc_done && poll_exit) begin
          status_q <= bc_rdata;
          error_q  <= !sr_ready | sr_failed(bc_rdata);
          state_q  <= S_CLRSR;
        end
        S_CLRSR: if (bc_done) state_q <= S_RDARR;
        S_RDARR: if (bc_done) begin
          state_q <= S_DONE;
          done_q  <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  flash_bus_cycle #(
    .WE_CYCLES(WE_CYCLES),
    .RD_CYCLES(RD_CYCLES)
  ) u_bus (
    .clk          (clk),
    .rst_n        (rst_n),
    .start_i      (bc_start),
    .req_i        (req),
    .done_o       (bc_done),
    .rdata_o      (bc_rdata),
    .fl_addr_o    (flAddr_o),
    .fl_data_o    (flData_o),
    .fl_data_oe_o (flDataOe_o),
    .fl_data_i    (flData_i),
    .fl_we_n_o    (flWE_o),
    .fl_oe_n_o    (flOE_o),
    .fl_ce_n_o    (flCE_o)
  );

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign error_o  = error_q;
  assign status_o = status_q;
  assign flVpen_o = busy_q;
  assign flRst_o  = 1'b1;
  assign flByte_o = 1'b1;

endmodule
